tm_recon_4x4: RTL and testbench

- Reconstruction stage that closes the loop around the 4x4 TrueMotion predictor.
- Takes a latched prediction block and a stream of signed residual rows, and emits clipped reconstructed rows over a valid/ready stream.
- Captures the block's bottom row, right column and bottom-right corner as the top, left and top_left border inputs for the next predictor invocation.

---
 rtl/tm_recon_4x4_if.sv | 34 +++
 rtl/tm_recon_4x4.sv | 147 ++++++++++++++
 tb/tb_tm_recon_4x4.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_recon_4x4_if.sv
// Stream and border bundle for the 4x4 TrueMotion reconstruction stage.
// The slave side is the reconstruction block; the master side feeds it.
interface tm_recon_4x4_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int RES_WIDTH  = 12
);
  logic                                      start;
  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred;
  logic                                      res_valid;
  logic                                      res_ready;
  logic [RES_WIDTH*BLOCK_SIZE-1:0]           res_row;
  logic                                      rec_valid;
  logic                                      rec_ready;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0]           rec_row;
  logic                                      rec_last;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0]           top_out;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0]           left_out;
  logic [BIT_WIDTH-1:0]                      top_left_out;
  logic                                      border_valid;
  logic                                      busy;

  modport master (
    output start, pred, res_valid, res_row, rec_ready,
    input  res_ready, rec_valid, rec_row, rec_last,
    input  top_out, left_out, top_left_out, border_valid, busy
  );

  modport slave (
    input  start, pred, res_valid, res_row, rec_ready,
    output res_ready, rec_valid, rec_row, rec_last,
    output top_out, left_out, top_left_out, border_valid, busy
  );
endinterface

// File: rtl/tm_recon_4x4.sv
// Reconstruction stage around the 4x4 TrueMotion predictor: adds signed
// residual rows to a latched prediction block, clips to pixel range, streams
// the rows out and keeps the bottom row / right column / corner as borders.
module tm_recon_4x4 #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int RES_WIDTH  = 12
) (
  input logic           clk,
  input logic           rst,
  tm_recon_4x4_if.slave bus
);
  localparam int ROW_W  = BIT_WIDTH * BLOCK_SIZE;
  localparam int PRED_W = ROW_W * BLOCK_SIZE;
  localparam int SUM_W  = RES_WIDTH + 2;
  localparam int CNT_W  = $clog2(BLOCK_SIZE + 1);
  localparam int IDX_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic [CNT_W-1:0]     ROWS     = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0]     LAST_ROW = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_WIDTH-1:0] PIX_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_row_in;
  logic [CNT_W-1:0]     r_row_out;
  logic [PRED_W-1:0]    r_pred;
  logic                 r_rec_valid;
  logic [ROW_W-1:0]     r_rec_row;
  logic [ROW_W-1:0]     r_top;
  logic [ROW_W-1:0]     r_left;
  logic [BIT_WIDTH-1:0] r_top_left;
  logic                 r_border_valid;

  logic [IDX_W-1:0]     w_row_idx;
  logic [ROW_W-1:0]     w_pred_row;
  logic [ROW_W-1:0]     w_rec_row_next;
  logic [BIT_WIDTH-1:0] w_rec_right;
  logic                 w_res_ready;
  logic                 w_res_fire;
  logic                 w_rec_fire;
  logic                 w_rec_last;

  // Truncated index is only used while row_in < BLOCK_SIZE, so it never aliases
  assign w_row_idx   = r_row_in[IDX_W-1:0];
  assign w_pred_row  = r_pred[int'(w_row_idx)*ROW_W +: ROW_W];
  assign w_rec_right = w_rec_row_next[ROW_W-1 -: BIT_WIDTH];

  // Single-entry output register with pass-through: a new row may enter in
  // the same cycle the held row leaves
  assign w_res_ready = (r_state == S_RUN) && (r_row_in < ROWS) &&
                       (!r_rec_valid || bus.rec_ready);
  assign w_res_fire  = bus.res_valid && w_res_ready;
  assign w_rec_fire  = r_rec_valid && bus.rec_ready;
  assign w_rec_last  = r_rec_valid && (r_row_out == LAST_ROW);

  // Per-column add and clip; the sum carries two extra bits so both the
  // negative and the overflow case are visible
  generate
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_col
      logic [BIT_WIDTH-1:0]       w_pix;
      logic [RES_WIDTH-1:0]       w_res;
      logic signed [SUM_W-1:0]    w_sum;
      assign w_pix = w_pred_row[gi*BIT_WIDTH +: BIT_WIDTH];
      assign w_res = bus.res_row[gi*RES_WIDTH +: RES_WIDTH];
      assign w_sum = $signed({{(SUM_W-BIT_WIDTH){1'b0}}, w_pix}) +
                     $signed({{2{w_res[RES_WIDTH-1]}}, w_res});
      assign w_rec_row_next[gi*BIT_WIDTH +: BIT_WIDTH] =
          w_sum[SUM_W-1]                   ? '0      :
          (|w_sum[SUM_W-2:BIT_WIDTH])      ? PIX_MAX :
                                             w_sum[BIT_WIDTH-1:0];
    end
  endgenerate

  // Block sequencing: accept start when not running, count rows, finish on last rec handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_row_in       <= '0;
      r_row_out      <= '0;
      r_pred         <= '0;
      r_border_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state        <= S_RUN;
            r_pred         <= bus.pred;
            r_row_in       <= '0;
            r_row_out      <= '0;
            r_border_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_res_fire) begin
            r_row_in <= r_row_in + CNT_ONE;
          end
          if (w_rec_fire) begin
            r_row_out <= r_row_out + CNT_ONE;
            if (w_rec_last) begin
              r_state        <= S_DONE;
              r_border_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output row register and border capture on each accepted residual row
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rec_valid <= 1'b0;
      r_rec_row   <= '0;
      r_top       <= '0;
      r_left      <= '0;
      r_top_left  <= '0;
    end else if (w_res_fire) begin
      r_rec_valid <= 1'b1;
      r_rec_row   <= w_rec_row_next;
      r_left[int'(w_row_idx)*BIT_WIDTH +: BIT_WIDTH] <= w_rec_right;
      if (r_row_in == LAST_ROW) begin
        r_top      <= w_rec_row_next;
        r_top_left <= w_rec_right;
      end
    end else if (w_rec_fire) begin
      r_rec_valid <= 1'b0;
    end
  end

  assign bus.res_ready    = w_res_ready;
  assign bus.rec_valid    = r_rec_valid;
  assign bus.rec_row      = r_rec_row;
  assign bus.rec_last     = w_rec_last;
  assign bus.top_out      = r_top;
  assign bus.left_out     = r_left;
  assign bus.top_left_out = r_top_left;
  assign bus.border_valid = r_border_valid;
  assign bus.busy         = (r_state == S_RUN);
endmodule

// File: tb/tb_tm_recon_4x4.sv
// Self-checking bench for tm_recon_4x4: directed tables plus randomized
// blocks checked against a plain-arithmetic reconstruction model.
`timescale 1ns/1ps
module tb_tm_recon_4x4;
  localparam int BW = 8;
  localparam int BS = 4;
  localparam int RW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tm_recon_4x4_if #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .RES_WIDTH(RW)) bus ();

  tm_recon_4x4 #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .RES_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_rows[4];

  typedef struct {
    logic [7:0] p;
    int         r;
    logic [7:0] e;
  } clip_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: each pixel is pred + residual, clamped to 0..255
  function automatic logic [31:0] model_row(input logic [127:0] p, input logic [47:0] r, input int j);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < BS; i++) begin
      logic [7:0]        pix;
      logic signed [11:0] rs;
      int                 s;
      pix = p[(j*BS+i)*BW +: BW];
      rs  = r[i*RW +: RW];
      s   = int'(pix) + int'(rs);
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      o[i*BW +: BW] = s[7:0];
    end
    return o;
  endfunction

  function automatic logic [47:0] pack_res(input int a, input int b, input int c, input int d);
    logic [47:0] v;
    v[11:0]  = a[11:0];
    v[23:12] = b[11:0];
    v[35:24] = c[11:0];
    v[47:36] = d[11:0];
    return v;
  endfunction

  // mode 0: always valid/ready; 1: random handshakes;
  // 2: hold rec_ready low 3 cycles while row 1 is presented; 3: like 0 plus a start pulse mid-block
  task automatic run_block(input logic [127:0] p, input logic [191:0] rows, input int mode, input string tag);
    logic [31:0] expq[$];
    logic [31:0] exp_rows[4];
    logic [31:0] held;
    logic [31:0] exp_left;
    logic        was_stalled;
    logic        expect_valid;
    logic        res_fire;
    logic        rec_fire;
    logic        exp_ready;
    int in_idx, out_idx, cyc, stall_left;
    bit pulsed;
    in_idx = 0; out_idx = 0; cyc = 0; stall_left = 3; pulsed = 0;
    was_stalled = 0; expect_valid = 0; held = '0;

    bus.pred = p; bus.start = 1'b1; bus.res_valid = 1'b0; bus.rec_ready = 1'b1;
    tick;
    bus.start = 1'b0;
    check({tag, " start_busy"}, 64'(bus.busy), 64'd1);
    check({tag, " start_bvalid"}, 64'(bus.border_valid), 64'd0);

    while (out_idx < BS && cyc < 200) begin
      bus.start = 1'b0;
      case (mode)
        1: begin
          bus.res_valid = (in_idx < BS) && ($urandom_range(0, 3) != 0);
          bus.rec_ready = ($urandom_range(0, 2) != 0);
        end
        2: begin
          bus.res_valid = (in_idx < BS);
          bus.rec_ready = !(out_idx == 1 && stall_left > 0);
        end
        3: begin
          bus.res_valid = (in_idx < BS);
          bus.rec_ready = 1'b1;
          if (in_idx == 2 && !pulsed) begin
            bus.start = 1'b1;
            bus.pred  = ~p;
            pulsed    = 1;
          end
        end
        default: begin
          bus.res_valid = (in_idx < BS);
          bus.rec_ready = 1'b1;
        end
      endcase
      if (in_idx < BS) bus.res_row = rows[in_idx*48 +: 48];
      else             bus.res_row = {16'($urandom), $urandom};

      @(negedge clk);
      exp_ready = (in_idx < BS) && (!bus.rec_valid || bus.rec_ready);
      check({tag, " res_ready"}, 64'(bus.res_ready), 64'(exp_ready));
      check({tag, " busy_run"}, 64'(bus.busy), 64'd1);
      check({tag, " rec_last"}, 64'(bus.rec_last), 64'(bus.rec_valid && out_idx == BS-1));
      if (expect_valid) check({tag, " latency"}, 64'(bus.rec_valid), 64'd1);
      if (was_stalled) begin
        check({tag, " hold_valid"}, 64'(bus.rec_valid), 64'd1);
        check({tag, " hold_row"}, 64'(bus.rec_row), 64'(held));
      end
      res_fire = bus.res_valid && bus.res_ready;
      rec_fire = bus.rec_valid && bus.rec_ready;
      if (rec_fire) begin
        if (expq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL %s spurious_row: got %0h expected none", tag, bus.rec_row);
        end else begin
          check({tag, " rec_row"}, 64'(bus.rec_row), 64'(expq.pop_front()));
        end
        if (out_idx < BS) got_rows[out_idx] = bus.rec_row;
        out_idx++;
      end
      if (mode == 2 && out_idx == 1 && bus.rec_valid && !bus.rec_ready) stall_left--;
      was_stalled  = bus.rec_valid && !bus.rec_ready;
      held         = bus.rec_row;
      expect_valid = res_fire;
      if (res_fire) begin
        exp_rows[in_idx] = model_row(p, rows[in_idx*48 +: 48], in_idx);
        expq.push_back(exp_rows[in_idx]);
        in_idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.res_valid = 1'b0;
    bus.start     = 1'b0;
    if (cyc >= 200) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got %0d rows expected %0d", tag, out_idx, BS);
    end else begin
      exp_left = '0;
      for (int j = 0; j < BS; j++) exp_left[j*BW +: BW] = exp_rows[j][31:24];
      check({tag, " done_busy"}, 64'(bus.busy), 64'd0);
      check({tag, " done_rec_valid"}, 64'(bus.rec_valid), 64'd0);
      check({tag, " done_bvalid"}, 64'(bus.border_valid), 64'd1);
      check({tag, " top_out"}, 64'(bus.top_out), 64'(exp_rows[BS-1]));
      check({tag, " left_out"}, 64'(bus.left_out), 64'(exp_left));
      check({tag, " top_left"}, 64'(bus.top_left_out), 64'(exp_rows[BS-1][31:24]));
    end
  endtask

  function automatic logic [127:0] rand_pred();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] rand_res();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clip_t        ctab[8];
    logic [31:0]  flat_exp[4];
    logic [127:0] p;
    logic [191:0] rr;
    logic [11:0]  r12;

    bus.start = 1'b0; bus.pred = '0; bus.res_valid = 1'b0;
    bus.res_row = '0; bus.rec_ready = 1'b0;

    ctab[0] = '{8'd250, 2047,  8'd255};
    ctab[1] = '{8'd3,   -2048, 8'd0};
    ctab[2] = '{8'd0,   0,     8'd0};
    ctab[3] = '{8'd255, 0,     8'd255};
    ctab[4] = '{8'd100, -100,  8'd0};
    ctab[5] = '{8'd100, -101,  8'd0};
    ctab[6] = '{8'd100, 155,   8'd255};
    ctab[7] = '{8'd100, 156,   8'd255};

    flat_exp[0] = {8'd104, 8'd103, 8'd102, 8'd101};
    flat_exp[1] = {8'd100, 8'd100, 8'd100, 8'd100};
    flat_exp[2] = {8'd95,  8'd95,  8'd95,  8'd95};
    flat_exp[3] = {8'd140, 8'd130, 8'd120, 8'd110};

    // Reset; a start coinciding with reset must be ignored
    rst = 1'b1;
    tick; tick;
    bus.start = 1'b1; bus.pred = {16{8'hAA}};
    tick;
    rst = 1'b0; bus.start = 1'b0;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst rec_valid", 64'(bus.rec_valid), 64'd0);
    check("rst rec_last", 64'(bus.rec_last), 64'd0);
    check("rst bvalid", 64'(bus.border_valid), 64'd0);
    check("rst rec_row", 64'(bus.rec_row), 64'd0);
    check("rst top_out", 64'(bus.top_out), 64'd0);
    check("rst left_out", 64'(bus.left_out), 64'd0);
    check("rst top_left", 64'(bus.top_left_out), 64'd0);
    bus.res_valid = 1'b1; bus.res_row = pack_res(5, 5, 5, 5); bus.rec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("idle res_ready", 64'(bus.res_ready), 64'd0);
      tick;
      check("idle rec_valid", 64'(bus.rec_valid), 64'd0);
    end
    bus.res_valid = 1'b0;

    // Flat block with table of expected rows and border constants
    p  = {16{8'd100}};
    rr = {pack_res(10, 20, 30, 40), pack_res(-5, -5, -5, -5), pack_res(0, 0, 0, 0), pack_res(1, 2, 3, 4)};
    run_block(p, rr, 0, "flat");
    for (int k = 0; k < 4; k++) check($sformatf("flat row%0d", k), 64'(got_rows[k]), 64'(flat_exp[k]));
    check("flat top_const", 64'(bus.top_out), 64'h8C82786E);
    check("flat left_const", 64'(bus.left_out), 64'h8C5F6468);
    check("flat topleft_const", 64'(bus.top_left_out), 64'h8C);

    // Backpressure while row 1 is presented, then back-to-back with ignored mid-block start
    run_block(rand_pred(), rand_res(), 2, "stall");
    run_block(rand_pred(), rand_res(), 3, "b2b");

    // Clipping table: entries k land at row k/4, col k%4
    p  = {16{8'h55}};
    rr = '0;
    for (int k = 0; k < 8; k++) begin
      p[k*8 +: 8]   = ctab[k].p;
      r12           = ctab[k].r[11:0];
      rr[k*12 +: 12] = r12;
    end
    run_block(p, rr, 1, "clip");
    for (int k = 0; k < 8; k++)
      check($sformatf("clip entry%0d", k), 64'(got_rows[k/4][(k%4)*8 +: 8]), 64'(ctab[k].e));

    // Randomized blocks with random handshakes
    for (int b = 0; b < 6; b++) run_block(rand_pred(), rand_res(), 1, $sformatf("rand%0d", b));

    // Reset after row 1 has left, with a residual still offered
    p  = rand_pred();
    rr = rand_res();
    bus.pred = p; bus.start = 1'b1; bus.res_valid = 1'b0; bus.rec_ready = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.res_valid = 1'b1; bus.res_row = rr[0 +: 48];
    tick;
    bus.res_row = rr[48 +: 48];
    tick;
    bus.res_valid = 1'b0;
    check("mid row1_valid", 64'(bus.rec_valid), 64'd1);
    check("mid row1", 64'(bus.rec_row), 64'(model_row(p, rr[48 +: 48], 1)));
    tick;
    rst = 1'b1; bus.res_valid = 1'b1; bus.res_row = rr[96 +: 48];
    tick;
    rst = 1'b0;
    check("mid rst busy", 64'(bus.busy), 64'd0);
    check("mid rst res_ready", 64'(bus.res_ready), 64'd0);
    check("mid rst rec_valid", 64'(bus.rec_valid), 64'd0);
    check("mid rst rec_row", 64'(bus.rec_row), 64'd0);
    check("mid rst left_out", 64'(bus.left_out), 64'd0);
    check("mid rst bvalid", 64'(bus.border_valid), 64'd0);
    tick;
    check("mid rst no_row", 64'(bus.rec_valid), 64'd0);
    bus.res_valid = 1'b0;
    run_block(rand_pred(), rand_res(), 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
